// File: rtl/ro_puf_ctrl_if.sv
// ---------------------------------------------------------------------------
// ro_puf_ctrl_if
//   Host-side handshake bundle of the ring-oscillator PUF measurement
//   controller.
//
//   master : host / consumer (drives start, challenge, resp_ready)
//   slave  : ro_puf_ctrl     (drives busy, resp, resp_err, resp_unstable,
//                             resp_valid)
//
//   start         1                 start pulse, accepted only when idle
//   challenge     RESP_W*2*SEL_W    slice i = {sel_b, sel_a} for response bit i
//   busy          1                 high from start accept until handshake
//   resp          RESP_W            response word
//   resp_err      1                 sticky saturation flag
//   resp_unstable RESP_W            per-bit low-margin mask
//   resp_valid    1                 response available
//   resp_ready    1                 consumer accepts response
// ---------------------------------------------------------------------------
interface ro_puf_ctrl_if #(
    parameter int RESP_W = 8,
    parameter int SEL_W  = 3
);
    logic                      start;
    logic [RESP_W*2*SEL_W-1:0] challenge;
    logic                      busy;
    logic [RESP_W-1:0]         resp;
    logic                      resp_err;
    logic [RESP_W-1:0]         resp_unstable;
    logic                      resp_valid;
    logic                      resp_ready;

    modport master (
        output start, challenge, resp_ready,
        input  busy, resp, resp_err, resp_unstable, resp_valid
    );

    modport slave (
        input  start, challenge, resp_ready,
        output busy, resp, resp_err, resp_unstable, resp_valid
    );
endinterface

// File: rtl/ro_puf_ctrl.sv
// ---------------------------------------------------------------------------
// ro_puf_ctrl
//   Measurement / response controller for a ring-oscillator PUF sitting
//   downstream of two edge counters (A and B). For every response bit it
//   selects an RO pair from the challenge, clears both counters (2 cycles),
//   gates them for WIN cycles, waits SETTLE cycles for the counts to cross
//   into this domain, then compares cnt_a > cnt_b. RESP_W bits form the
//   response word, handed off with valid/ready.
//
//   Optional feature macro: PUF_MARGIN_EN
//     defined   : bits whose |cnt_a - cnt_b| < MARGIN are flagged in
//                 resp_unstable
//     undefined : resp_unstable is constant 0, no difference logic
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       start/challenge/busy/resp*/resp_valid/resp_ready
//   o_sel_a, o_sel_b  RO mux selects for counters A and B
//   o_cnt_clr         clear of both counters (registered)
//   o_cnt_up          count enable of both counters (registered)
//   i_cnt_a, i_cnt_b  counter values
//   i_rco_a, i_rco_b  counter saturation (ripple carry out)
// ---------------------------------------------------------------------------
module ro_puf_ctrl #(
    parameter int N      = 32,
    parameter int WIN    = 1024,
    parameter int SETTLE = 4,
    parameter int RESP_W = 8,
    parameter int SEL_W  = 3,
    parameter int MARGIN = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    ro_puf_ctrl_if.slave     bus,
    output logic [SEL_W-1:0] o_sel_a,
    output logic [SEL_W-1:0] o_sel_b,
    output logic             o_cnt_clr,
    output logic             o_cnt_up,
    input  logic [N-1:0]     i_cnt_a,
    input  logic [N-1:0]     i_cnt_b,
    input  logic             i_rco_a,
    input  logic             i_rco_b
);

    localparam int CHAL_W  = RESP_W * 2 * SEL_W;
    localparam int SLICE_W = 2 * SEL_W;
    localparam int IDX_W   = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam int TMR_MAX = (WIN > SETTLE) ? WIN : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    // Parameter sanity, caught at elaboration.
    if (WIN < 1 || SETTLE < 1 || RESP_W < 1 || SEL_W < 1 || MARGIN < 0) begin : g_param_check
        $error("ro_puf_ctrl: illegal parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_MEASURE = 3'd2,
        S_SETTLE  = 3'd3,
        S_COMPARE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TMR_W-1:0]    r_tmr;
    logic                w_tmr_done;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_inc;
    logic                w_last;
    logic [CHAL_W-1:0]   r_chal;
    logic [SLICE_W-1:0]  w_slice;
    logic [SEL_W-1:0]    r_sel_a;
    logic [SEL_W-1:0]    r_sel_b;
    logic                r_cnt_clr;
    logic                r_cnt_up;
    logic                r_busy;
    logic                r_valid;
    logic [RESP_W-1:0]   r_resp;
    logic                r_err;
    logic                w_gt;
    logic                w_sat;
    logic                w_accept;

    assign w_tmr_done = (r_tmr == {TMR_W{1'b0}});
    assign w_last     = (r_idx == IDX_W'(RESP_W - 1));
    assign w_gt       = (i_cnt_a > i_cnt_b);
    assign w_sat      = i_rco_a | i_rco_b;
    assign w_accept   = (r_state == S_IDLE) && bus.start;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; every timed state leaves when its timer hits 0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_CLEAR;
                else           w_next = S_IDLE;
            end
            S_CLEAR: begin
                if (w_tmr_done) w_next = S_MEASURE;
                else            w_next = S_CLEAR;
            end
            S_MEASURE: begin
                if (w_tmr_done) w_next = S_SETTLE;
                else            w_next = S_MEASURE;
            end
            S_SETTLE: begin
                if (w_tmr_done) w_next = S_COMPARE;
                else            w_next = S_SETTLE;
            end
            S_COMPARE: begin
                if (w_last) w_next = S_DONE;
                else        w_next = S_CLEAR;
            end
            S_DONE: begin
                // resp_valid is high for the whole of DONE.
                if (bus.resp_ready) w_next = S_IDLE;
                else                w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Phase timer: loaded with (length-1) on state entry, counts down to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr <= {TMR_W{1'b0}};
        end else if (w_next != r_state) begin
            case (w_next)
                S_CLEAR:   r_tmr <= TMR_W'(1);
                S_MEASURE: r_tmr <= TMR_W'(WIN - 1);
                S_SETTLE:  r_tmr <= TMR_W'(SETTLE - 1);
                default:   r_tmr <= {TMR_W{1'b0}};
            endcase
        end else if (!w_tmr_done) begin
            r_tmr <= r_tmr - TMR_W'(1);
        end else begin
            r_tmr <= r_tmr;
        end
    end

    // Challenge slice for the bit about to enter CLEAR. On start the
    // challenge register is loading in the same edge, so bit 0 comes
    // straight from the bus.
    always_comb begin
        w_idx_inc = r_idx;
        w_slice   = {SLICE_W{1'b0}};
        if (w_last) begin
            w_idx_inc = r_idx;
        end else begin
            w_idx_inc = r_idx + IDX_W'(1);
        end
        if (r_state == S_IDLE) begin
            w_slice = bus.challenge[SLICE_W-1:0];
        end else begin
            w_slice = r_chal[int'(w_idx_inc) * SLICE_W +: SLICE_W];
        end
    end

    // Challenge capture and bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chal <= {CHAL_W{1'b0}};
            r_idx  <= {IDX_W{1'b0}};
        end else if (w_accept) begin
            r_chal <= bus.challenge;
            r_idx  <= {IDX_W{1'b0}};
        end else if ((r_state == S_COMPARE) && !w_last) begin
            r_chal <= r_chal;
            r_idx  <= w_idx_inc;
        end else begin
            r_chal <= r_chal;
            r_idx  <= r_idx;
        end
    end

    // RO selects: updated only on entry to CLEAR so they stay put through
    // MEASURE, SETTLE and COMPARE of the same bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_a <= {SEL_W{1'b0}};
            r_sel_b <= {SEL_W{1'b0}};
        end else if ((w_next == S_CLEAR) && (r_state != S_CLEAR)) begin
            r_sel_a <= w_slice[SEL_W-1:0];
            r_sel_b <= w_slice[SLICE_W-1:SEL_W];
        end else begin
            r_sel_a <= r_sel_a;
            r_sel_b <= r_sel_b;
        end
    end

    // Control outputs registered from the next state, so they line up
    // exactly with the state they belong to; clr and up are mutually
    // exclusive by construction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_clr <= 1'b0;
            r_cnt_up  <= 1'b0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            r_cnt_clr <= (w_next == S_CLEAR);
            r_cnt_up  <= (w_next == S_MEASURE);
            r_busy    <= (w_next != S_IDLE);
            r_valid   <= (w_next == S_DONE);
        end
    end

    // Response word and sticky saturation flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp <= {RESP_W{1'b0}};
            r_err  <= 1'b0;
        end else if (w_accept) begin
            r_resp <= {RESP_W{1'b0}};
            r_err  <= 1'b0;
        end else if (r_state == S_COMPARE) begin
            r_resp[r_idx] <= w_gt;
            r_err         <= r_err | w_sat;
        end else begin
            r_resp <= r_resp;
            r_err  <= r_err;
        end
    end

`ifdef PUF_MARGIN_EN
    logic [N-1:0]      w_diff;
    logic              w_low;
    logic [RESP_W-1:0] r_unstable;

    // Absolute count difference at N bits.
    always_comb begin
        w_diff = {N{1'b0}};
        if (i_cnt_a > i_cnt_b) begin
            w_diff = i_cnt_a - i_cnt_b;
        end else begin
            w_diff = i_cnt_b - i_cnt_a;
        end
    end

    assign w_low = (w_diff < N'(MARGIN));

    // Per-bit low-margin mask; the raw compare result in resp is unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_unstable <= {RESP_W{1'b0}};
        end else if (w_accept) begin
            r_unstable <= {RESP_W{1'b0}};
        end else if (r_state == S_COMPARE) begin
            r_unstable[r_idx] <= w_low;
        end else begin
            r_unstable <= r_unstable;
        end
    end

    assign bus.resp_unstable = r_unstable;
`else
    assign bus.resp_unstable = {RESP_W{1'b0}};
`endif

    assign o_sel_a        = r_sel_a;
    assign o_sel_b        = r_sel_b;
    assign o_cnt_clr      = r_cnt_clr;
    assign o_cnt_up       = r_cnt_up;
    assign bus.busy       = r_busy;
    assign bus.resp_valid = r_valid;
    assign bus.resp       = r_resp;
    assign bus.resp_err   = r_err;

endmodule
